// File: rtl/execute_bru_bco_arbiter_if.sv
// Branch-predictor update bus: registered valid/ready handshake with the BCO payload
// and its source lane.
interface execute_bru_bco_arbiter_if;
  logic        o_bp_valid;
  logic        i_bp_ready;
  logic [31:0] o_bp_pc;
  logic [1:0]  o_bp_oldpattern;
  logic        o_bp_taken;
  logic [31:0] o_bp_target;
  logic        o_bp_lane;

  modport master (
    output o_bp_valid, o_bp_pc, o_bp_oldpattern, o_bp_taken, o_bp_target, o_bp_lane,
    input  i_bp_ready
  );

  modport slave (
    input  o_bp_valid, o_bp_pc, o_bp_oldpattern, o_bp_taken, o_bp_target, o_bp_lane,
    output i_bp_ready
  );
endinterface

// File: rtl/execute_bru_bco_arbiter.sv
// Merges branch-commit outcomes from two BRU lanes through per-lane FIFOs and a
// round-robin arbiter onto one registered branch-predictor update port.
module execute_bru_bco_arbiter #(
  parameter int DEPTH       = 4,
  parameter int AFULL_SLACK = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_bco0_valid,
  input  logic [31:0] i_bco0_pc,
  input  logic [1:0]  i_bco0_oldpattern,
  input  logic        i_bco0_taken,
  input  logic [31:0] i_bco0_target,
  input  logic        i_bco1_valid,
  input  logic [31:0] i_bco1_pc,
  input  logic [1:0]  i_bco1_oldpattern,
  input  logic        i_bco1_taken,
  input  logic [31:0] i_bco1_target,
  execute_bru_bco_arbiter_if.master bp,
  output logic        o_lane0_afull,
  output logic        o_lane1_afull,
  output logic        o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] L_SLACK = CW'(AFULL_SLACK);

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  oldpattern;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t          w_in   [2];
  logic          w_vin  [2];
  ent_t          r_mem  [2][DEPTH];
  logic [PW-1:0] r_wr   [2];
  logic [PW-1:0] r_rd   [2];
  logic [CW-1:0] r_cnt  [2];
  logic          w_ne   [2];
  logic          w_push [2];
  logic          w_pop  [2];

  logic r_vld, r_rr, r_lane, r_ovf;
  ent_t r_out;
  logic w_load, w_grant, w_pop_any, w_drop_any;

  assign w_in[0]  = {i_bco0_pc, i_bco0_oldpattern, i_bco0_taken, i_bco0_target};
  assign w_in[1]  = {i_bco1_pc, i_bco1_oldpattern, i_bco1_taken, i_bco1_target};
  assign w_vin[0] = i_bco0_valid;
  assign w_vin[1] = i_bco1_valid;

  // Arbitration only matters on a load cycle; a lone non-empty lane wins outright.
  always_comb begin
    w_load = ~r_vld | bp.i_bp_ready;
    for (int l = 0; l < 2; l++) w_ne[l] = (r_cnt[l] != '0);
    if (w_ne[0] && w_ne[1]) w_grant = r_rr;
    else                    w_grant = ~w_ne[0];
    w_pop[0]  = w_load & w_ne[0] & ~w_grant;
    w_pop[1]  = w_load & w_ne[1] &  w_grant;
    w_pop_any = w_pop[0] | w_pop[1];
    // A full lane still accepts a push when it is drained in the same cycle.
    for (int l = 0; l < 2; l++) w_push[l] = w_vin[l] & ((r_cnt[l] < L_DEPTH) | w_pop[l]);
    w_drop_any = (w_vin[0] & ~w_push[0]) | (w_vin[1] & ~w_push[1]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int l = 0; l < 2; l++) begin
        r_cnt[l] <= '0;
        r_wr[l]  <= '0;
        r_rd[l]  <= '0;
      end
      r_vld <= 1'b0;
      r_rr  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (w_push[l]) r_wr[l] <= r_wr[l] + PW'(1);
        if (w_pop[l])  r_rd[l] <= r_rd[l] + PW'(1);
        case ({w_push[l], w_pop[l]})
          2'b10:   r_cnt[l] <= r_cnt[l] + CW'(1);
          2'b01:   r_cnt[l] <= r_cnt[l] - CW'(1);
          default: r_cnt[l] <= r_cnt[l];
        endcase
      end
      if (w_load)     r_vld <= w_pop_any;
      if (w_pop_any)  r_rr  <= ~w_grant;
      if (w_drop_any) r_ovf <= 1'b1;
    end
  end

  // Storage and payload carry no reset; validity is tracked by the counts and r_vld.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++)
      if (w_push[l]) r_mem[l][r_wr[l]] <= w_in[l];
    if (w_pop_any) begin
      r_out  <= r_mem[w_grant][r_rd[w_grant]];
      r_lane <= w_grant;
    end
  end

  assign bp.o_bp_valid      = r_vld;
  assign bp.o_bp_pc         = r_out.pc;
  assign bp.o_bp_oldpattern = r_out.oldpattern;
  assign bp.o_bp_taken      = r_out.taken;
  assign bp.o_bp_target     = r_out.target;
  assign bp.o_bp_lane       = r_lane;

  assign o_lane0_afull = (L_DEPTH - r_cnt[0]) <= L_SLACK;
  assign o_lane1_afull = (L_DEPTH - r_cnt[1]) <= L_SLACK;
  assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_execute_bru_bco_arbiter.sv
// Bench for execute_bru_bco_arbiter: directed scenarios then random traffic, compared
// cycle by cycle against a queue-based reference model.
module tb_execute_bru_bco_arbiter;
  localparam int DEPTH = 4;
  localparam int SLACK = 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        v0, v1, tk0, tk1, rdy;
  logic [31:0] pc0, pc1, tg0, tg1;
  logic [1:0]  op0, op1;
  logic        afull0, afull1, ovf;

  execute_bru_bco_arbiter_if bp_if ();
  assign bp_if.i_bp_ready = rdy;

  execute_bru_bco_arbiter #(.DEPTH(DEPTH), .AFULL_SLACK(SLACK)) dut (
    .clk(clk), .resetn(resetn),
    .i_bco0_valid(v0), .i_bco0_pc(pc0), .i_bco0_oldpattern(op0),
    .i_bco0_taken(tk0), .i_bco0_target(tg0),
    .i_bco1_valid(v1), .i_bco1_pc(pc1), .i_bco1_oldpattern(op1),
    .i_bco1_taken(tk1), .i_bco1_target(tg1),
    .bp(bp_if),
    .o_lane0_afull(afull0), .o_lane1_afull(afull1), .o_overflow(ovf)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  op;
    logic        tk;
    logic [31:0] tg;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  ent_t m_out;
  logic m_vld, m_lane, m_rr, m_ovf;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_vld = 1'b0;
    m_rr  = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the reference: drain into the output slot first, then enqueue,
  // so a lane drained this edge has room for a new arrival.
  task automatic model_edge();
    bit   load;
    ent_t e;
    load = !m_vld || rdy;
    if (load) begin
      if (q0.size() > 0 && (q1.size() == 0 || m_rr == 1'b0)) begin
        m_out = q0.pop_front(); m_lane = 1'b0; m_vld = 1'b1; m_rr = 1'b1;
      end else if (q1.size() > 0) begin
        m_out = q1.pop_front(); m_lane = 1'b1; m_vld = 1'b1; m_rr = 1'b0;
      end else begin
        m_vld = 1'b0;
      end
    end
    if (v0) begin
      e = '{pc: pc0, op: op0, tk: tk0, tg: tg0};
      if (q0.size() < DEPTH) q0.push_back(e); else m_ovf = 1'b1;
    end
    if (v1) begin
      e = '{pc: pc1, op: op1, tk: tk1, tg: tg1};
      if (q1.size() < DEPTH) q1.push_back(e); else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(bp_if.o_bp_valid), 32'(m_vld));
    if (m_vld) begin
      chk("pc",     bp_if.o_bp_pc,            m_out.pc);
      chk("oldpat", 32'(bp_if.o_bp_oldpattern), 32'(m_out.op));
      chk("taken",  32'(bp_if.o_bp_taken),    32'(m_out.tk));
      chk("target", bp_if.o_bp_target,        m_out.tg);
      chk("lane",   32'(bp_if.o_bp_lane),     32'(m_lane));
    end
    chk("afull0",   32'(afull0), 32'((DEPTH - q0.size()) <= SLACK));
    chk("afull1",   32'(afull1), 32'((DEPTH - q1.size()) <= SLACK));
    chk("overflow", 32'(ovf),    32'(m_ovf));
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model at the
  // posedge, and compare at the following negedge.
  task automatic cyc(input bit a0, input logic [31:0] p0, input bit a1,
                     input logic [31:0] p1, input bit r);
    v0 = a0; pc0 = p0; op0 = 2'($urandom); tk0 = 1'($urandom); tg0 = $urandom;
    v1 = a1; pc1 = p1; op1 = 2'($urandom); tk1 = 1'($urandom); tg1 = $urandom;
    rdy = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    v0 = 0; v1 = 0; rdy = 0; pc0 = 0; pc1 = 0; op0 = 0; op1 = 0;
    tk0 = 0; tk1 = 0; tg0 = 0; tg1 = 0;
    resetn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bp_if.o_bp_valid), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    chk("rst_afull", 32'({afull0, afull1}), 32'd0);
    resetn = 1'b1;

    // Single lane0 update: visible two cycles after it is presented.
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h1000, 0, 0, 1);
    chk("t1_lat1", 32'(bp_if.o_bp_valid), 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("t1_valid", 32'(bp_if.o_bp_valid), 32'd1);
    chk("t1_pc",    bp_if.o_bp_pc, 32'h1000);
    chk("t1_lane",  32'(bp_if.o_bp_lane), 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("t1_idle", 32'(bp_if.o_bp_valid), 32'd0);

    // Both lanes every cycle: alternating grants, per-lane order kept.
    for (int i = 0; i < 4; i++) cyc(1, 32'h2000 + i, 1, 32'h3000 + i, 1);
    repeat (6) cyc(0, 0, 0, 0, 1);

    // Stalled output with six lane0 arrivals: one held, four queued, one dropped.
    for (int i = 1; i <= 6; i++) cyc(1, 32'h4000 + i, 0, 0, 0);
    chk("t3_ovf",   32'(ovf), 32'd1);
    chk("t3_afull", 32'(afull0), 32'd1);
    chk("t3_head",  bp_if.o_bp_pc, 32'h4001);
    repeat (7) cyc(0, 0, 0, 0, 1);
    do_reset();

    // Full FIFO drained and filled in the same cycle is not an overflow.
    for (int i = 1; i <= 5; i++) cyc(1, 32'h5000 + i, 0, 0, 0);
    cyc(1, 32'h5006, 0, 0, 1);
    chk("t4_ovf",   32'(ovf), 32'd0);
    chk("t4_afull", 32'(afull0), 32'd1);
    repeat (7) cyc(0, 0, 0, 0, 1);

    // Held output stays stable under backpressure, then pops exactly once.
    cyc(0, 0, 1, 32'h6000, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    chk("t5_hold_pc",   bp_if.o_bp_pc, 32'h6000);
    chk("t5_hold_lane", 32'(bp_if.o_bp_lane), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_popped", 32'(bp_if.o_bp_valid), 32'd0);

    // Asynchronous reset mid-stream flushes everything at once.
    for (int i = 0; i < 3; i++) cyc(1, 32'h7000 + i, 1, 32'h7100 + i, 0);
    #2 resetn = 1'b0;
    #1 chk("t6_async_valid", 32'(bp_if.o_bp_valid), 32'd0);
    model_reset();
    v0 = 0; v1 = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) cyc(0, 0, 0, 0, 1);
    chk("t6_ovf", 32'(ovf), 32'd0);

    // Random traffic at varying load and backpressure.
    for (int blk = 0; blk < 5; blk++) begin
      int p;
      int rp;
      p  = 20 + blk * 20;
      rp = 90 - blk * 15;
      for (int i = 0; i < 300; i++)
        cyc($urandom_range(0, 99) < p, 32'hA000_0000 + blk * 1000 + i,
            $urandom_range(0, 99) < p, 32'hB000_0000 + blk * 1000 + i,
            $urandom_range(0, 99) < rp);
      repeat (12) cyc(0, 0, 0, 0, 1);
      if (blk == 2) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
